// File: rtl/adder_speed_test.sv
// adder_speed_test: two independent WIDTH-bit adders sharing one clock.
//   nopi: unpipelined full-width add, latency 2 (input regs -> output reg).
//   pipd: two half-width stages with a registered carry, latency 3.
// Optional feature macro: ADDER_SPEEDTEST_COUT_EN adds add_nopi_cout and
// add_pipd_cout, the MSB carries aligned with their sums.
module adder_speed_test #(
  parameter  int WIDTH    = 64,
  localparam int LO_WIDTH = WIDTH / 2,
  localparam int HI_WIDTH = WIDTH - LO_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] add_nopi_op0,
  input  logic [WIDTH-1:0] add_nopi_op1,
  output logic [WIDTH-1:0] add_nopi_out,
  input  logic [WIDTH-1:0] add_pipd_op0,
  input  logic [WIDTH-1:0] add_pipd_op1,
  output logic [WIDTH-1:0] add_pipd_out
`ifdef ADDER_SPEEDTEST_COUT_EN
  ,
  output logic             add_nopi_cout,
  output logic             add_pipd_cout
`endif
);

  // nopi path registers
  logic [WIDTH-1:0]    nopi_op0_r;
  logic [WIDTH-1:0]    nopi_op1_r;
  logic [WIDTH-1:0]    nopi_out_r;
  logic [WIDTH-1:0]    nopi_sum_s;

  // pipd path registers
  logic [WIDTH-1:0]    pipd_op0_r;
  logic [WIDTH-1:0]    pipd_op1_r;
  logic [LO_WIDTH-1:0] lo_sum_r;
  logic                lo_carry_r;
  logic [HI_WIDTH-1:0] hi_op0_r;
  logic [HI_WIDTH-1:0] hi_op1_r;
  logic [WIDTH-1:0]    pipd_out_r;
  logic [LO_WIDTH:0]   lo_sum_s;
  logic [HI_WIDTH-1:0] hi_sum_s;

`ifdef ADDER_SPEEDTEST_COUT_EN
  logic nopi_cout_s;
  logic pipd_cout_s;
  logic nopi_cout_r;
  logic pipd_cout_r;
`endif

  // Full-width sum of the nopi input registers (the long carry chain under test).
  always_comb begin
`ifdef ADDER_SPEEDTEST_COUT_EN
    {nopi_cout_s, nopi_sum_s} = {1'b0, nopi_op0_r} + {1'b0, nopi_op1_r};
`else
    nopi_sum_s = nopi_op0_r + nopi_op1_r;
`endif
  end

  // Stage 1 low slice sum; the extra MSB is the carry into the upper slice.
  always_comb begin
    lo_sum_s = {1'b0, pipd_op0_r[LO_WIDTH-1:0]} + {1'b0, pipd_op1_r[LO_WIDTH-1:0]};
  end

  // Stage 2 upper slice sum with the registered carry in; odd WIDTH lands here.
  always_comb begin
`ifdef ADDER_SPEEDTEST_COUT_EN
    {pipd_cout_s, hi_sum_s} = {1'b0, hi_op0_r} + {1'b0, hi_op1_r}
                              + (HI_WIDTH+1)'(lo_carry_r);
`else
    hi_sum_s = hi_op0_r + hi_op1_r + HI_WIDTH'(lo_carry_r);
`endif
  end

  // nopi path: capture operands, then register the full-width sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nopi_op0_r <= '0;
      nopi_op1_r <= '0;
      nopi_out_r <= '0;
    end else begin
      nopi_op0_r <= add_nopi_op0;
      nopi_op1_r <= add_nopi_op1;
      nopi_out_r <= nopi_sum_s;
    end
  end

  // pipd path: capture operands, register low sum/carry and delayed upper
  // operands, then join the upper sum with the delayed low sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipd_op0_r <= '0;
      pipd_op1_r <= '0;
      lo_sum_r   <= '0;
      lo_carry_r <= 1'b0;
      hi_op0_r   <= '0;
      hi_op1_r   <= '0;
      pipd_out_r <= '0;
    end else begin
      pipd_op0_r <= add_pipd_op0;
      pipd_op1_r <= add_pipd_op1;
      lo_sum_r   <= lo_sum_s[LO_WIDTH-1:0];
      lo_carry_r <= lo_sum_s[LO_WIDTH];
      hi_op0_r   <= pipd_op0_r[WIDTH-1:LO_WIDTH];
      hi_op1_r   <= pipd_op1_r[WIDTH-1:LO_WIDTH];
      pipd_out_r <= {hi_sum_s, lo_sum_r};
    end
  end

`ifdef ADDER_SPEEDTEST_COUT_EN
  // Carry-out registers, aligned with their respective sum registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nopi_cout_r <= 1'b0;
      pipd_cout_r <= 1'b0;
    end else begin
      nopi_cout_r <= nopi_cout_s;
      pipd_cout_r <= pipd_cout_s;
    end
  end

  assign add_nopi_cout = nopi_cout_r;
  assign add_pipd_cout = pipd_cout_r;
`endif

  assign add_nopi_out = nopi_out_r;
  assign add_pipd_out = pipd_out_r;

endmodule

// File: tb/tb_adder_speed_test.sv
// Directed self-checking bench for adder_speed_test (WIDTH = 64).
// Honours ADDER_SPEEDTEST_COUT_EN when defined.
module tb_adder_speed_test;

  logic        clk;
  logic        rst_n;
  logic [63:0] nopi_op0;
  logic [63:0] nopi_op1;
  logic [63:0] nopi_out;
  logic [63:0] pipd_op0;
  logic [63:0] pipd_op1;
  logic [63:0] pipd_out;
`ifdef ADDER_SPEEDTEST_COUT_EN
  logic        nopi_cout;
  logic        pipd_cout;
`endif

  int n_vec;
  int n_err;

  adder_speed_test #(.WIDTH(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .add_nopi_op0 (nopi_op0),
    .add_nopi_op1 (nopi_op1),
    .add_nopi_out (nopi_out),
    .add_pipd_op0 (pipd_op0),
    .add_pipd_op1 (pipd_op1),
    .add_pipd_out (pipd_out)
`ifdef ADDER_SPEEDTEST_COUT_EN
    ,
    .add_nopi_cout(nopi_cout),
    .add_pipd_cout(pipd_cout)
`endif
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
    nopi_op0 = a;
    nopi_op1 = b;
    pipd_op0 = c;
    pipd_op1 = d;
  endtask

  logic [63:0] ra, rb, rc, rd;

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b1;
    set_ops(64'd5, 64'd7, 64'd5, 64'd7);

    // Asynchronous reset: outputs clear before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_nopi", nopi_out, 64'd0);
    chk("rst_pipd", pipd_out, 64'd0);

    // Release and check latency 2 / 3.
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("rel_e1_nopi", nopi_out, 64'd0);
    tick();
    chk("rel_e2_nopi", nopi_out, 64'd12);
    chk("rel_e2_pipd", pipd_out, 64'd0);
    tick();
    chk("rel_e3_pipd", pipd_out, 64'd12);

    // Random operands, each held for 4 edges.
    for (int i = 0; i < 5; i++) begin
      ra = 64'($urandom) * 64'($urandom);
      rb = 64'($urandom) * 64'($urandom);
      rc = 64'($urandom) * 64'($urandom);
      rd = 64'($urandom) * 64'($urandom);
      set_ops(ra, rb, rc, rd);
      for (int k = 0; k < 4; k++) tick();
      chk("rand_nopi", nopi_out, ra + rb);
      chk("rand_pipd", pipd_out, rc + rd);
    end

    // Carry across the LO_WIDTH boundary.
    set_ops(64'h0000_0000_FFFF_FFFF, 64'd1, 64'h0000_0000_FFFF_FFFF, 64'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("mid_nopi", nopi_out, 64'h0000_0001_0000_0000);
    chk("mid_pipd", pipd_out, 64'h0000_0001_0000_0000);
`ifdef ADDER_SPEEDTEST_COUT_EN
    chk("mid_nopi_cout", {63'd0, nopi_cout}, 64'd0);
    chk("mid_pipd_cout", {63'd0, pipd_cout}, 64'd0);
`endif

    // All-ones + 1 wraps to zero.
    set_ops(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("wrap_nopi", nopi_out, 64'd0);
    chk("wrap_pipd", pipd_out, 64'd0);
`ifdef ADDER_SPEEDTEST_COUT_EN
    chk("wrap_nopi_cout", {63'd0, nopi_cout}, 64'd1);
    chk("wrap_pipd_cout", {63'd0, pipd_cout}, 64'd1);
`endif

    // Streaming: new operands every cycle, results back-to-back in order.
    set_ops(64'd1, 64'd2, 64'd1, 64'd2);
    tick();
    set_ops(64'd3, 64'd4, 64'd3, 64'd4);
    tick();
    chk("strm_e2_nopi", nopi_out, 64'd3);
    chk("strm_e2_pipd", pipd_out, 64'd0);
    set_ops(64'd5, 64'd6, 64'd5, 64'd6);
    tick();
    chk("strm_e3_nopi", nopi_out, 64'd7);
    chk("strm_e3_pipd", pipd_out, 64'd3);
    tick();
    chk("strm_e4_nopi", nopi_out, 64'd11);
    chk("strm_e4_pipd", pipd_out, 64'd7);
    tick();
    chk("strm_e5_nopi", nopi_out, 64'd11);
    chk("strm_e5_pipd", pipd_out, 64'd11);

    // Reset mid-stream with values in flight in the pipd path.
    set_ops(64'd10, 64'd20, 64'd10, 64'd20);
    tick();
    set_ops(64'd30, 64'd40, 64'd30, 64'd40);
    tick();
    rst_n = 1'b0;
    #1;
    chk("mrst_nopi", nopi_out, 64'd0);
    chk("mrst_pipd", pipd_out, 64'd0);
    set_ops(64'd100, 64'd200, 64'd100, 64'd200);
    @(negedge clk) rst_n = 1'b1;
    tick();
    chk("mrst_e1_nopi", nopi_out, 64'd0);
    chk("mrst_e1_pipd", pipd_out, 64'd0);
    tick();
    chk("mrst_e2_nopi", nopi_out, 64'd300);
    chk("mrst_e2_pipd", pipd_out, 64'd0);
    tick();
    chk("mrst_e3_pipd", pipd_out, 64'd300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
